jam_cost_table: RTL and testbench

//  Upstream cost-table stage for JAM. Accepts the 8x8 worker/job cost matrix as a row-major

---
 rtl/jam_pkg.sv | 10 +
 rtl/jam_cost_mem.sv | 25 ++
 rtl/jam_cost_table.sv | 55 +++++
 tb/tb_jam_cost_table.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, state encoding and types for the JAM cost table.
package jam_pkg;
    localparam int COST_W = 7;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 2 * IDX_W;
    localparam int DEPTH  = 1 << ADDR_W;
    typedef enum logic {LOAD, SERVE} tbl_state_e;
    typedef logic [COST_W-1:0] cost_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/jam_cost_mem.sv
// jam_cost_mem: DEPTH x COST_W register file, one sync write port and one registered read port.
module jam_cost_mem
    import jam_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  we_i,
    input  addr_t wr_addr_i,
    input  cost_t wr_data_i,
    input  logic  re_i,
    input  addr_t rd_addr_i,
    output cost_t rd_data_o
);
    cost_t mem_q [DEPTH];
    cost_t rd_q;
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    end
    // A disabled read forces the output to zero rather than holding it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_q <= '0;
        else         rd_q <= re_i ? mem_q[rd_addr_i] : '0;
    end
    assign rd_data_o = rd_q;
endmodule

// File: rtl/jam_cost_table.sv
// jam_cost_table: loads an 8x8 cost matrix over valid/ready, then serves
// registered (W,J) lookups until JOB_DONE releases it for the next pattern.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_VALID,
    input  logic [COST_W-1:0] LD_DATA,
    output logic              LD_READY,
    output logic              TBL_READY,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              JOB_DONE,
    output logic              LD_OVF
);
    tbl_state_e state_q, state_d;
    addr_t      wr_ptr_q, wr_ptr_d;
    logic       ovf_q, ovf_d;
    logic       xfer, re;
    always_comb begin
        state_d  = state_q;
        xfer     = LD_VALID && (state_q == LOAD);
        wr_ptr_d = xfer ? wr_ptr_q + 1'b1 : wr_ptr_q;
        ovf_d    = ovf_q | (LD_VALID && (state_q == SERVE));
        re       = (state_q == SERVE) && !JOB_DONE;
        if (state_q == LOAD && xfer && (&wr_ptr_q)) state_d = SERVE;
        if (state_q == SERVE && JOB_DONE)           state_d = LOAD;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end
    jam_cost_mem u_mem (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .we_i      (xfer),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (LD_DATA),
        .re_i      (re),
        .rd_addr_i ({W, J}),
        .rd_data_o (Cost)
    );
    assign LD_READY  = (state_q == LOAD);
    assign TBL_READY = (state_q == SERVE);
    assign LD_OVF    = ovf_q;
endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table: directed loads and lookups with a scoreboard for Cost.
module tb_jam_cost_table;
    logic       CLK, RST, LD_VALID, LD_READY, TBL_READY, JOB_DONE, LD_OVF;
    logic [6:0] LD_DATA, Cost;
    logic [2:0] W, J;
    logic       lk_v;
    int         checks = 0, failures = 0, xfers = 0;
    int         exp_mem [64];
    int         sb [$];

    jam_cost_table dut (
        .CLK(CLK), .RST(RST), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
        .LD_READY(LD_READY), .TBL_READY(TBL_READY), .W(W), .J(J),
        .Cost(Cost), .JOB_DONE(JOB_DONE), .LD_OVF(LD_OVF)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) if (LD_VALID && LD_READY) xfers <= xfers + 1;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic look(input int a, input int e);
        W = a[5:3];
        J = a[2:0];
        lk_v = 1;
        sb.push_back(e);
    endtask

    task automatic load(input int n, input bit tog, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            int v;
            v = (base + step * i) % 128;
            if (tog) begin
                @(negedge CLK);
                LD_VALID = 0;
                look(i, 0);
            end
            @(negedge CLK);
            if (i == 63) begin
                chk("ld_ready_before_last", LD_READY, 1);
                chk("tbl_ready_before_last", TBL_READY, 0);
            end
            LD_VALID = 1;
            LD_DATA = v[6:0];
            if (n == 64) exp_mem[i] = v;
            look(63 - i, 0);
        end
        @(negedge CLK);
        LD_VALID = 0;
        lk_v = 0;
        if (n == 64) begin
            chk("tbl_ready_after_load", TBL_READY, 1);
            chk("ld_ready_after_load", LD_READY, 0);
        end
    endtask

    task automatic sweep();
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            look(i, exp_mem[i]);
        end
        @(negedge CLK);
        lk_v = 0;
    endtask

    task automatic job_done();
        @(negedge CLK);
        JOB_DONE = 1;
        chk("tbl_ready_at_done", TBL_READY, 1);
        look(5, 0);
        @(negedge CLK);
        JOB_DONE = 0;
        lk_v = 0;
        chk("tbl_ready_after_done", TBL_READY, 0);
        chk("ld_ready_after_done", LD_READY, 1);
    endtask

    initial begin
        int x0;
        RST = 0; LD_VALID = 0; LD_DATA = 0; W = 0; J = 0; JOB_DONE = 0; lk_v = 0;
        fork
            forever begin
                bit pend;
                @(posedge CLK);
                pend = lk_v;
                @(negedge CLK);
                if (pend) begin
                    if (sb.size() == 0) chk("sb_underflow", 1, 0);
                    else chk("cost", Cost, sb.pop_front());
                end
            end
        join_none
        repeat (3) @(negedge CLK);
        chk("rst_cost", Cost, 0);
        chk("rst_tbl_ready", TBL_READY, 0);
        chk("rst_ld_ovf", LD_OVF, 0);
        chk("rst_ld_ready", LD_READY, 1);
        RST = 1;
        // stream i, then single lookup (3,5) and full sweep
        load(64, 0, 0, 1);
        @(negedge CLK);
        look(29, 29);
        @(negedge CLK);
        lk_v = 0;
        sweep();
        job_done();
        // stalled load
        x0 = xfers;
        load(64, 1, 1, 3);
        chk("xfer_count", xfers - x0, 64);
        sweep();
        job_done();
        // all-100 pattern
        load(64, 0, 100, 0);
        sweep();
        // entry offered while serving is dropped
        @(negedge CLK);
        LD_VALID = 1;
        LD_DATA = 77;
        @(negedge CLK);
        LD_VALID = 0;
        chk("ovf_set", LD_OVF, 1);
        sweep();
        chk("ovf_sticky", LD_OVF, 1);
        // JOB_DONE together with LD_VALID
        @(negedge CLK);
        JOB_DONE = 1;
        LD_VALID = 1;
        LD_DATA = 77;
        @(negedge CLK);
        JOB_DONE = 0;
        LD_VALID = 0;
        chk("simul_tbl_ready", TBL_READY, 0);
        chk("simul_ovf", LD_OVF, 1);
        load(64, 0, 5, 7);
        sweep();
        // async reset while serving a nonzero cost
        @(negedge CLK);
        look(9, exp_mem[9]);
        @(negedge CLK);
        lk_v = 0;
        #2 RST = 0;
        #1;
        chk("serve_rst_cost", Cost, 0);
        chk("serve_rst_tbl_ready", TBL_READY, 0);
        chk("serve_rst_ovf", LD_OVF, 0);
        chk("serve_rst_ld_ready", LD_READY, 1);
        @(negedge CLK);
        RST = 1;
        // reset after a partial load, then full reload
        load(20, 0, 50, 1);
        #2 RST = 0;
        #1;
        chk("mid_rst_tbl_ready", TBL_READY, 0);
        chk("mid_rst_cost", Cost, 0);
        chk("mid_rst_ld_ready", LD_READY, 1);
        @(negedge CLK);
        RST = 1;
        load(64, 0, 127, 127);
        sweep();
        repeat (3) @(negedge CLK);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
